// File: rtl/frame_pixel_streamer.sv
// Raster-order pixel source for the Harris detector.
// Reads one greyscale frame from a synchronous byte RAM and streams it with row/frame tags.
module frame_pixel_streamer #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int H_BLANK = 0,
    parameter int ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pixel,
    output logic              pixel_valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HB_W = (H_BLANK > 2) ? $clog2(H_BLANK) : 1;

    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
    localparam logic [HB_W-1:0] HB_LAST  = HB_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [HB_W-1:0]   r_hb_cnt;
    logic              r_busy;
    logic              r_done;

    logic              r_s1_valid;
    logic              r_s1_sof;
    logic              r_s1_eol;
    logic              r_s1_eof;

    logic [7:0]        r_pixel;
    logic              r_pv;
    logic              r_sof;
    logic              r_eol;
    logic              r_eof;

    logic              w_start_ok;
    logic              w_abort;
    logic              w_rd;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_hb_last;
    logic              w_sof_tag;
    logic              w_eof_tag;

    // A start landing on the done pulse is dropped so frames never overlap.
    assign w_start_ok = (r_state == ST_IDLE) && start && !r_done;
    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_rd       = (r_state == ST_STREAM) && !pause && !abort;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_hb_last  = (r_hb_cnt == HB_LAST);
    assign w_sof_tag  = (r_col == '0) && (r_row == '0);
    assign w_eof_tag  = w_col_last && w_row_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rd && w_col_last) begin
                    if (w_row_last)       w_state_nxt = ST_DRAIN;
                    else if (H_BLANK > 0) w_state_nxt = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (w_hb_last) w_state_nxt = ST_STREAM;
            end
            ST_DRAIN: begin
                if (abort)              w_state_nxt = ST_IDLE;
                else if (r_pv && r_eof) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_hb_cnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (r_state == ST_DRAIN) && !abort && r_pv && r_eof;

            if (w_start_ok || w_abort) begin
                r_col  <= '0;
                r_row  <= '0;
                r_addr <= '0;
            end else if (w_rd) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                r_addr <= w_eof_tag ? '0 : r_addr + 1'b1;
            end

            // Blanking keeps counting while paused.
            if (r_state != ST_HBLANK) r_hb_cnt <= '0;
            else                      r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_pixel    <= '0;
            r_pv       <= 1'b0;
            r_sof      <= 1'b0;
            r_eol      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_s1_valid <= w_rd;
            r_s1_sof   <= w_rd && w_sof_tag;
            r_s1_eol   <= w_rd && w_col_last;
            r_s1_eof   <= w_rd && w_eof_tag;

            // Abort flushes the in-flight read; pixel keeps its last value.
            if (w_abort) begin
                r_pv  <= 1'b0;
                r_sof <= 1'b0;
                r_eol <= 1'b0;
                r_eof <= 1'b0;
            end else begin
                r_pv  <= r_s1_valid;
                r_sof <= r_s1_valid && r_s1_sof;
                r_eol <= r_s1_valid && r_s1_eol;
                r_eof <= r_s1_valid && r_s1_eof;
                if (r_s1_valid) r_pixel <= mem_rdata;
            end
        end
    end

    assign mem_rd_en   = w_rd;
    assign mem_addr    = r_addr;
    assign pixel       = r_pixel;
    assign pixel_valid = r_pv;
    assign sof         = r_sof;
    assign eol         = r_eol;
    assign eof         = r_eof;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
